// File: rtl/lock_code_serializer.sv
// Keypad code-word FIFO feeding a bit-serial lock sequence detector.
// Define LOCK_SER_LSB_FIRST_EN to shift LSB first (default MSB first).
module lock_code_serializer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int GAP   = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   a,
  output logic                   a_valid,
  output logic                   word_done,
  output logic [$clog2(DEPTH):0] level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       gcnt_q, gcnt_d;
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [LW-1:0]    level_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             push, pop;
  logic             cur_bit;
  logic [WIDTH-1:0] sh_next;

`ifdef LOCK_SER_LSB_FIRST_EN
  assign cur_bit = sh_q[0];
  assign sh_next = {1'b0, sh_q[WIDTH-1:1]};
`else
  assign cur_bit = sh_q[WIDTH-1];
  assign sh_next = {sh_q[WIDTH-2:0], 1'b0};
`endif

  assign in_ready  = (level_q != LW'(DEPTH)) && !RST;
  assign push      = in_valid && in_ready;
  assign a_valid   = (state_q == S_SHIFT);
  assign a         = a_valid && cur_bit;
  assign word_done = a_valid && (cnt_q == '0);
  assign level     = level_q;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    pop     = 1'b0;
    unique case (1'b1)
      state_q == S_IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          sh_d    = mem_q[rptr_q];
          cnt_d   = CW'(WIDTH - 1);
          state_d = S_SHIFT;
        end
      end
      state_q == S_SHIFT: begin
        if (cnt_q == '0) begin
          if (GAP > 0) begin
            state_d = S_GAP;
            gcnt_d  = 3'(GAP - 1);
          end else if (level_q != '0) begin
            // back-to-back: next word replaces the finished one
            pop   = 1'b1;
            sh_d  = mem_q[rptr_q];
            cnt_d = CW'(WIDTH - 1);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          sh_d  = sh_next;
          cnt_d = cnt_q - 1'b1;
        end
      end
      state_q == S_GAP: begin
        if (gcnt_q == '0) state_d = S_IDLE;
        else              gcnt_d  = gcnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      level_q <= level_q + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= in_data;
  end
endmodule

// File: tb/tb_lock_code_serializer.sv
// Directed bench for lock_code_serializer: GAP=1 and GAP=0 instances.
module tb_lock_code_serializer;
  localparam int W = 4;
  localparam int D = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [W-1:0]         in_data;
  logic                 in_valid, in_ready;
  logic                 a, a_valid, word_done;
  logic [$clog2(D):0]   level;

  logic [W-1:0]         in_data0;
  logic                 in_valid0, in_ready0;
  logic                 a0, a_valid0, word_done0;
  logic [$clog2(D):0]   level0;

  int n_chk  = 0;
  int n_fail = 0;

  lock_code_serializer #(.WIDTH(W), .DEPTH(D), .GAP(1)) u_dut (
    .CLK(clk), .RST(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .a_valid(a_valid), .word_done(word_done), .level(level)
  );

  lock_code_serializer #(.WIDTH(W), .DEPTH(D), .GAP(0)) u_dut0 (
    .CLK(clk), .RST(rst),
    .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .a(a0), .a_valid(a_valid0), .word_done(word_done0), .level(level0)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic bitof(input logic [W-1:0] w, input int i);
`ifdef LOCK_SER_LSB_FIRST_EN
    return w[i];
`else
    return w[W-1-i];
`endif
  endfunction

  task automatic expect_word(input string tag, input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      check($sformatf("%s_v%0d", tag, i), a_valid, 1);
      check($sformatf("%s_a%0d", tag, i), a, bitof(w, i));
      check($sformatf("%s_wd%0d", tag, i), word_done, (i == W - 1));
      tick();
    end
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (a_valid !== 1'b1 && k < 12) begin
      tick();
      k++;
    end
    check({tag, "_wait"}, a_valid, 1);
  endtask

  logic [W-1:0] fill [6];
  logic [W-1:0] w0 [3];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fill = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    w0   = '{4'h5, 4'hC, 4'h3};
    rst = 1'b1;
    in_data = '0;   in_valid = 1'b0;
    in_data0 = '0;  in_valid0 = 1'b0;
    tick();
    tick();
    check("rst_ready", in_ready, 0);
    check("rst_a", a, 0);
    check("rst_av", a_valid, 0);
    check("rst_wd", word_done, 0);
    check("rst_lvl", level, 0);
    rst = 1'b0;
    #1;
    check("rel_ready", in_ready, 1);

    // single word 1001, GAP=1
    in_data = 4'b1001; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("s1_lvl", level, 1);
    check("s1_idle_av", a_valid, 0);
    tick();
    check("s1_lvl_pop", level, 0);
    expect_word("s1", 4'b1001);
    check("s1_gap_a", a, 0);
    check("s1_gap_av", a_valid, 0);
    check("s1_gap_wd", word_done, 0);
    tick();

    // two words back to back at the input
    in_data = 4'b1001; in_valid = 1'b1;
    tick();
    in_data = 4'b0110;
    tick();
    in_valid = 1'b0;
    check("s2_lvl", level, 1);
    expect_word("s2w0", 4'b1001);
    check("s2_gap_av", a_valid, 0);
    tick();
    check("s2_idle_av", a_valid, 0);
    check("s2_idle_lvl", level, 1);
    tick();
    expect_word("s2w1", 4'b0110);
    check("s2_gap2_av", a_valid, 0);
    tick();

    // fill to full while first word shifts; F held off
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          int k = 0;
          in_data = fill[i];
          in_valid = 1'b1;
          if (i == 5) begin
            check("s3_full_ready", in_ready, 0);
            check("s3_full_lvl", level, 4);
          end
          while (in_ready !== 1'b1 && k < 40) begin
            tick();
            k++;
          end
          check($sformatf("s3_push%0d", i), in_ready, 1);
          tick();
        end
        in_valid = 1'b0;
      end
      begin
        for (int j = 0; j < 6; j++) begin
          wait_valid($sformatf("s3w%0d", j));
          expect_word($sformatf("s3w%0d", j), fill[j]);
        end
      end
    join
    check("s3_end_lvl", level, 0);
    check("s3_end_av", a_valid, 0);
    tick();

    // bit order
    in_data = 4'b0011; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    expect_word("s6", 4'b0011);
    tick();

    // reset mid-word with two words queued
    in_data = 4'b1001; in_valid = 1'b1;
    tick();
    in_data = 4'h7;
    tick();
    in_data = 4'h8;
    tick();
    in_valid = 1'b0;
    check("s4_lvl", level, 2);
    check("s4_av", a_valid, 1);
    check("s4_a", a, bitof(4'b1001, 1));
    rst = 1'b1;
    #1;
    check("s4_rst_a", a, 0);
    check("s4_rst_av", a_valid, 0);
    check("s4_rst_lvl", level, 0);
    check("s4_rst_ready", in_ready, 0);
    check("s4_rst_wd", word_done, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("s4_rel_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("s4_quiet_av%0d", i), a_valid, 0);
      check($sformatf("s4_quiet_lvl%0d", i), level, 0);
    end

    // GAP=0 instance: three words, continuous stream
    in_data0 = w0[0]; in_valid0 = 1'b1;
    tick();
    in_data0 = w0[1];
    tick();
    in_data0 = w0[2];
    for (int k = 0; k < 3 * W; k++) begin
      check($sformatf("s5_v%0d", k), a_valid0, 1);
      check($sformatf("s5_a%0d", k), a0, bitof(w0[k / W], k % W));
      check($sformatf("s5_wd%0d", k), word_done0, (k % W == W - 1));
      tick();
      if (k == 0) in_valid0 = 1'b0;
    end
    check("s5_end_av", a_valid0, 0);
    check("s5_end_lvl", level0, 0);
    check("s5_end_ready", in_ready0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
